// File: rtl/hit_event_packetizer.sv
// Buffers per-note judgement events and frames each one as a byte packet for the UART transmitter.
// Define HIT_PKT_REPORT_SCORE_EN to carry the 16-bit score snapshot (5-byte packet, else 3-byte).
module hit_event_packetizer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_valid,
    input  logic [1:0]  hit_lane,
    input  logic [1:0]  hit_result,
    input  logic [31:0] score,
    input  logic        tx_data_ready,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [7:0]  drop_count
);

`ifdef HIT_PKT_REPORT_SCORE_EN
    localparam int unsigned EntryW = 20;
    typedef enum logic [2:0] {StIdle, StHdr, StEvt, StScH, StScL, StChk} state_e;
`else
    localparam int unsigned EntryW = 4;
    typedef enum logic [1:0] {StIdle, StHdr, StEvt, StChk} state_e;
`endif

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    logic [EntryW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [7:0]        drop_q;

    state_e            state_q;
    logic [EntryW-1:0] pkt_q;
    logic [3:0]        pkt_seq_q;
    logic [3:0]        seq_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;

    logic              push, pop, xfer;
    logic [EntryW-1:0] entry_in;
    logic [1:0]        pkt_result, pkt_lane;
    logic [7:0]        evt_byte;

`ifdef HIT_PKT_REPORT_SCORE_EN
    logic [7:0] score_hi, score_lo, chk_byte;
    logic       unused_score_hi;

    assign entry_in        = {hit_result, hit_lane, score[15:0]};
    assign score_hi        = pkt_q[15:8];
    assign score_lo        = pkt_q[7:0];
    assign chk_byte        = evt_byte ^ score_hi ^ score_lo;
    assign unused_score_hi = ^score[31:16];
`else
    logic unused_score;

    assign entry_in     = {hit_result, hit_lane};
    assign unused_score = ^score;
`endif

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    assign push = hit_valid && (count_q != FullCount);
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign xfer = tx_valid_q && tx_data_ready;

    assign pkt_result = pkt_q[EntryW-1 -: 2];
    assign pkt_lane   = pkt_q[EntryW-3 -: 2];
    assign evt_byte   = {pkt_seq_q, pkt_result, pkt_lane};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (hit_valid && !push && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pkt_q      <= '0;
            pkt_seq_q  <= '0;
            seq_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        pkt_q      <= mem_q[rd_ptr_q];
                        pkt_seq_q  <= seq_q;
                        seq_q      <= seq_q + 4'd1;
                        tx_data_q  <= HEADER_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= StHdr;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        tx_data_q <= evt_byte;
                        state_q   <= StEvt;
                    end
                end
`ifdef HIT_PKT_REPORT_SCORE_EN
                StEvt: begin
                    if (xfer) begin
                        tx_data_q <= score_hi;
                        state_q   <= StScH;
                    end
                end
                StScH: begin
                    if (xfer) begin
                        tx_data_q <= score_lo;
                        state_q   <= StScL;
                    end
                end
                StScL: begin
                    if (xfer) begin
                        tx_data_q <= chk_byte;
                        state_q   <= StChk;
                    end
                end
`else
                // Without a score field the checksum over the EVT byte alone is EVT itself.
                StEvt: begin
                    if (xfer) begin
                        tx_data_q <= evt_byte;
                        state_q   <= StChk;
                    end
                end
`endif
                StChk: begin
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign tx_data_valid = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != StIdle) || (count_q != '0);
    assign drop_count    = drop_q;

endmodule
